// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: forwarding select encoding, per-stage
// destination tag and the architectural register address width.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        FWD_DEC = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    // Destination record of an in-flight instruction.
    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [REG_ADDR_W-1:0] dst;
    } stage_tag_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage / hazard-unit bundle.
//   master : decode side, drives hold, flush and the ID instruction fields,
//            receives the EX selects, stall (and stall_count).
//   slave  : hazard_forward_unit.
// Optional: HFU_PERF_CNT_EN adds the stall_count signal and CNT_W.
interface hazard_forward_unit_if
#(
`ifdef HFU_PERF_CNT_EN
    parameter int unsigned CNT_W      = 16,
`endif
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
);
    logic                  hold;
    logic                  flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic [REG_ADDR_W-1:0] id_src_st;
    logic                  id_use1;
    logic                  id_use2;
    logic                  id_use_st;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_wr;
    logic                  id_load;
    logic [1:0]            reg1_sel;
    logic [1:0]            reg2_sel;
    logic [1:0]            ST_reg_sel;
    logic                  stall;
`ifdef HFU_PERF_CNT_EN
    logic [CNT_W-1:0]      stall_count;
`endif

    modport master (
        output hold, flush, id_valid, id_src1, id_src2, id_src_st,
               id_use1, id_use2, id_use_st, id_dst, id_wr, id_load,
        input  reg1_sel, reg2_sel, ST_reg_sel, stall
`ifdef HFU_PERF_CNT_EN
             , stall_count
`endif
    );

    modport slave (
        input  hold, flush, id_valid, id_src1, id_src2, id_src_st,
               id_use1, id_use2, id_use_st, id_dst, id_wr, id_load,
        output reg1_sel, reg2_sel, ST_reg_sel, stall
`ifdef HFU_PERF_CNT_EN
             , stall_count
`endif
    );

endinterface

// File: rtl/fwd_match.sv
// Per-source forwarding match against the EX and MEM destination tags.
//   src, use_src     : source register address and its read-enable
//   ex_tag, mem_tag  : destinations currently in EX and MEM
//   sel_c            : next EX select for this source (younger producer wins)
//   hit_e_c          : source matches the EX producer (load-use candidate)
module fwd_match
    import cpu_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
)
(
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  stage_tag_t            ex_tag,
    input  stage_tag_t            mem_tag,
    output fwd_sel_t              sel_c,
    output logic                  hit_e_c
);

    logic hit_m_c;

    assign hit_e_c = use_src & ex_tag.valid  & ex_tag.wr  & (src == ex_tag.dst);
    assign hit_m_c = use_src & mem_tag.valid & mem_tag.wr & (src == mem_tag.dst);

    // EX producer reaches MEM next cycle; MEM producer reaches WB.
    always_comb begin
        sel_c = FWD_DEC;
        if (hit_e_c) begin
            sel_c = FWD_MEM;
        end else if (hit_m_c) begin
            sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller at the ID/EX boundary.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_forward_unit_if.slave (ID fields, hold, flush in;
//              registered EX selects, combinational stall out)
// Tracks EX/MEM destination tags, registers forwarding selects for the
// instruction entering EX and inserts a one-cycle bubble on load-use.
// Optional: HFU_PERF_CNT_EN adds a saturating load-use stall counter.
module hazard_forward_unit
    import cpu_pkg::*;
#(
`ifdef HFU_PERF_CNT_EN
    parameter int unsigned CNT_W      = 16,
`endif
    parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W
)
(
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_unit_if.slave bus
);

    stage_tag_t ex_tag;
    stage_tag_t mem_tag;
    logic       ex_load;    // load flag of the EX instruction; MEM never needs it

    fwd_sel_t   nxt1_c;
    fwd_sel_t   nxt2_c;
    fwd_sel_t   nxt_st_c;
    logic       hit1_c;
    logic       hit2_c;
    logic       hit_st_c;
    logic       bubble_c;

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match1 (
        .src(bus.id_src1), .use_src(bus.id_use1),
        .ex_tag(ex_tag), .mem_tag(mem_tag),
        .sel_c(nxt1_c), .hit_e_c(hit1_c)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match2 (
        .src(bus.id_src2), .use_src(bus.id_use2),
        .ex_tag(ex_tag), .mem_tag(mem_tag),
        .sel_c(nxt2_c), .hit_e_c(hit2_c)
    );

    fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_st (
        .src(bus.id_src_st), .use_src(bus.id_use_st),
        .ex_tag(ex_tag), .mem_tag(mem_tag),
        .sel_c(nxt_st_c), .hit_e_c(hit_st_c)
    );

    // Load result only exists at end of MEM: a consumer right behind it waits.
    // A flush squashes the consumer, so it never counts as a stall.
    assign bus.stall = bus.id_valid & ~bus.flush & ex_load & (hit1_c | hit2_c | hit_st_c);
    assign bubble_c  = bus.stall | bus.flush | ~bus.id_valid;

    // Tag pipeline and registered EX selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_tag         <= '0;
            mem_tag        <= '0;
            ex_load        <= 1'b0;
            bus.reg1_sel   <= 2'b00;
            bus.reg2_sel   <= 2'b00;
            bus.ST_reg_sel <= 2'b00;
        end else if (!bus.hold) begin
            mem_tag <= ex_tag;
            if (bubble_c) begin
                ex_tag.valid   <= 1'b0;
                ex_load        <= 1'b0;
                bus.reg1_sel   <= 2'b00;
                bus.reg2_sel   <= 2'b00;
                bus.ST_reg_sel <= 2'b00;
            end else begin
                ex_tag.valid   <= 1'b1;
                ex_tag.wr      <= bus.id_wr;
                ex_tag.dst     <= bus.id_dst;
                ex_load        <= bus.id_load;
                bus.reg1_sel   <= 2'(nxt1_c);
                bus.reg2_sel   <= 2'(nxt2_c);
                bus.ST_reg_sel <= 2'(nxt_st_c);
            end
        end
    end

`ifdef HFU_PERF_CNT_EN
    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_count <= '0;
        end else if (!bus.hold && bus.stall && (bus.stall_count != {CNT_W{1'b1}})) begin
            bus.stall_count <= bus.stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed test-plan sequences
// followed by randomized instruction streams, checked against a slot-based
// pipeline model.
module tb_hazard_forward_unit;
    import cpu_pkg::*;

    typedef struct {
        logic       valid;
        logic [3:0] s1, s2, sst;
        logic       u1, u2, ust;
        logic [3:0] dst;
        logic       wr, load;
    } instr_t;

    typedef struct {
        logic [1:0] s1, s2, sst;
        int         cnt;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_forward_unit_if bus ();
    hazard_forward_unit u_dut (.clk(clk), .rst(rst), .bus(bus));

    // Model: the instructions sitting in EX and MEM, and the selects that EX sees.
    instr_t     m_ex, m_mem;
    logic [1:0] m_sel1, m_sel2, m_selst;
    int         m_cnt;

    out_t q_out[$];
    logic q_stall[$];
    int   total = 0;
    int   bad   = 0;
    logic last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t mk(input logic v, input logic [3:0] s1, input logic u1,
                                  input logic [3:0] s2, input logic u2,
                                  input logic [3:0] sst, input logic ust,
                                  input logic [3:0] dst, input logic wr, input logic ld);
        instr_t i;
        i.valid = v; i.s1 = s1; i.u1 = u1; i.s2 = s2; i.u2 = u2;
        i.sst = sst; i.ust = ust; i.dst = dst; i.wr = wr; i.load = ld;
        return i;
    endfunction

    // Youngest in-flight writer of src decides where the value comes from.
    function automatic logic [1:0] fwd(input logic [3:0] src, input logic u);
        if (!u) return 2'b00;
        if (m_ex.valid && m_ex.wr && m_ex.dst == src) return 2'b01;
        if (m_mem.valid && m_mem.wr && m_mem.dst == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic reads(input instr_t id, input logic [3:0] r);
        return (id.u1 && id.s1 == r) || (id.u2 && id.s2 == r) || (id.ust && id.sst == r);
    endfunction

    // One clock of stimulus: drive at negedge, predict stall now and outputs after the edge.
    task automatic step(input instr_t id, input logic h, input logic f, input logic r);
        logic st;
        logic [1:0] n1, n2, nst;
        @(negedge clk);
        rst           = r;
        bus.hold      = h;
        bus.flush     = f;
        bus.id_valid  = id.valid;
        bus.id_src1   = id.s1;
        bus.id_src2   = id.s2;
        bus.id_src_st = id.sst;
        bus.id_use1   = id.u1;
        bus.id_use2   = id.u2;
        bus.id_use_st = id.ust;
        bus.id_dst    = id.dst;
        bus.id_wr     = id.wr;
        bus.id_load   = id.load;

        st = id.valid && !f && m_ex.valid && m_ex.load && m_ex.wr && reads(id, m_ex.dst);
        q_stall.push_back(st);
        last_stall = st;

        n1 = fwd(id.s1, id.u1);
        n2 = fwd(id.s2, id.u2);
        nst = fwd(id.sst, id.ust);
        if (r) begin
            m_ex.valid = 1'b0; m_mem.valid = 1'b0;
            m_sel1 = 2'b00; m_sel2 = 2'b00; m_selst = 2'b00;
            m_cnt = 0;
        end else if (!h) begin
            m_mem = m_ex;
            m_mem.load = 1'b0;
            if (st || f || !id.valid) begin
                m_ex.valid = 1'b0;
                m_sel1 = 2'b00; m_sel2 = 2'b00; m_selst = 2'b00;
            end else begin
                m_ex = id;
                m_sel1 = n1; m_sel2 = n2; m_selst = nst;
            end
            if (st && m_cnt < 65535) m_cnt++;
        end
        q_out.push_back('{s1: m_sel1, s2: m_sel2, sst: m_selst, cnt: m_cnt});
    endtask

    // Registered outputs, one entry per clock edge.
    initial begin
        out_t o;
        forever begin
            @(posedge clk);
            #1;
            if (q_out.size() > 0) begin
                o = q_out.pop_front();
                chk("reg1_sel", 32'(bus.reg1_sel), 32'(o.s1));
                chk("reg2_sel", 32'(bus.reg2_sel), 32'(o.s2));
                chk("ST_reg_sel", 32'(bus.ST_reg_sel), 32'(o.sst));
`ifdef HFU_PERF_CNT_EN
                chk("stall_count", 32'(bus.stall_count), 32'(o.cnt));
`endif
            end
        end
    end

    // Combinational stall, sampled mid low-phase after inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (q_stall.size() > 0) chk("stall", 32'(bus.stall), 32'(q_stall.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        instr_t nop, a, b, cur;
        m_ex = '{default: '0}; m_mem = '{default: '0};
        m_sel1 = 2'b00; m_sel2 = 2'b00; m_selst = 2'b00; m_cnt = 0;
        last_stall = 1'b0;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.hold = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_src1 = 0; bus.id_src2 = 0; bus.id_src_st = 0;
        bus.id_use1 = 0; bus.id_use2 = 0; bus.id_use_st = 0;
        bus.id_dst = 0; bus.id_wr = 0; bus.id_load = 0;

        // Reset, then idle.
        step(nop, 0, 0, 1);
        step(nop, 0, 0, 1);
        step(nop, 0, 0, 0);
        step(nop, 0, 0, 0);
        @(posedge clk); #1;
        chk("idle_reg1", 32'(bus.reg1_sel), 0);
        chk("idle_stall", 32'(bus.stall), 0);

        // ADD R3 <- R1,R2 ; SUB R4 <- R3,R2 : reg1 from MEM, no stall.
        step(mk(1, 1, 1, 2, 1, 0, 0, 3, 1, 0), 0, 0, 0);
        step(mk(1, 3, 1, 2, 1, 0, 0, 4, 1, 0), 0, 0, 0);
        #1 chk("alu_alu_nostall", 32'(bus.stall), 0);
        @(posedge clk); #1 chk("alu_alu_reg1", 32'(bus.reg1_sel), 1);

        // ADD R3 ; NOP ; ST [R1] <- R3 : store data from WB.
        step(mk(1, 1, 1, 2, 1, 0, 0, 3, 1, 0), 0, 0, 0);
        step(nop, 0, 0, 0);
        step(mk(1, 1, 1, 0, 0, 3, 1, 0, 0, 0), 0, 0, 0);
        @(posedge clk); #1 chk("store_wb", 32'(bus.ST_reg_sel), 2);

        // LOAD R5 ; ADD R6 <- R2,R5 : one stall, bubble, then reg2 from WB.
        a = mk(1, 2, 1, 5, 1, 0, 0, 6, 1, 0);
        step(mk(1, 1, 1, 0, 0, 0, 0, 5, 1, 1), 0, 0, 0);
        step(a, 0, 0, 0);
        #1 chk("load_use_stall", 32'(bus.stall), 1);
        @(posedge clk); #1 chk("load_use_bubble", 32'(bus.reg2_sel), 0);
        step(a, 0, 0, 0);
        #1 chk("load_use_release", 32'(bus.stall), 0);
        @(posedge clk); #1 chk("load_use_reg2", 32'(bus.reg2_sel), 2);
`ifdef HFU_PERF_CNT_EN
        chk("load_use_count", 32'(bus.stall_count), 1);
`endif

        // Two writers of R7 in flight: the younger one (EX) wins.
        step(mk(1, 1, 1, 2, 1, 0, 0, 7, 1, 0), 0, 0, 0);
        step(mk(1, 2, 1, 1, 1, 0, 0, 7, 1, 0), 0, 0, 0);
        step(mk(1, 7, 1, 1, 1, 0, 0, 9, 1, 0), 0, 0, 0);
        @(posedge clk); #1 chk("younger_wins", 32'(bus.reg1_sel), 1);

        // R0 forwards like any register.
        step(mk(1, 1, 1, 2, 1, 0, 0, 0, 1, 0), 0, 0, 0);
        step(mk(1, 1, 1, 0, 1, 0, 0, 9, 1, 0), 0, 0, 0);
        @(posedge clk); #1 chk("r0_forward", 32'(bus.reg2_sel), 1);

        // LOAD R8 ; consumer held 3 cycles while stalled, then flushed.
        b = mk(1, 8, 1, 1, 0, 0, 0, 10, 1, 0);
        step(mk(1, 1, 1, 0, 0, 0, 0, 8, 1, 1), 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(b, 1, 0, 0);
            #1 chk("hold_stall", 32'(bus.stall), 1);
        end
        step(b, 0, 1, 0);
        #1 chk("flush_beats_stall", 32'(bus.stall), 0);
        @(posedge clk); #1 chk("flush_bubble", 32'(bus.reg1_sel), 0);
`ifdef HFU_PERF_CNT_EN
        chk("hold_flush_count", 32'(bus.stall_count), 1);
`endif

        // Reset in the middle of a load-use stall drops it.
        step(mk(1, 1, 1, 0, 0, 0, 0, 9, 1, 1), 0, 0, 0);
        step(mk(1, 9, 1, 0, 0, 0, 0, 4, 1, 0), 0, 0, 1);
        step(mk(1, 9, 1, 0, 0, 0, 0, 4, 1, 0), 0, 0, 0);
        #1 chk("reset_drops_stall", 32'(bus.stall), 0);

        // Random streams on a small register set to provoke hazards.
        cur = nop;
        for (int n = 0; n < 1500; n++) begin
            logic h, f, r;
            h = ($urandom_range(0, 9) == 0);
            f = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 59) == 0);
            if (!(last_stall && $urandom_range(0, 4) != 0)) begin
                cur = mk($urandom_range(0, 6) != 0,
                         4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                         4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                         4'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                         4'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                         $urandom_range(0, 2) == 0);
            end
            step(cur, h, f, r);
        end

        step(nop, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3;
        chk("queues_drained", 32'(q_out.size() + q_stall.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard and forwarding controller that drives the EXECUTE stage operand and store-data select lines (`reg1_sel`, `reg2_sel`, `ST_reg_sel`). It sits at the ID/EX boundary and keeps a two-deep tag pipeline recording the destinations of the instructions in the EX and MEM stages. From those tags it registers the forwarding selects for the instruction entering EX. It inserts a one-cycle bubble on load-use hazards.

## Interface
- `REG_ADDR_W`, default 4: register address width (16 architectural registers).
- `CNT_W`, default 16: stall counter width. Used only with `HFU_PERF_CNT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hold`  in  1  global pipeline freeze (memory wait); all state holds.
- `flush`  in  1  taken branch resolved in EX; the ID instruction is squashed.
- `id_valid`  in  1  ID stage holds a real instruction.
- `id_src1`, `id_src2`, `id_src_st`  in  REG_ADDR_W each  ALU operand 1, ALU operand 2 and store-data source registers.
- `id_use1`, `id_use2`, `id_use_st`  in  1 each  matching source is actually read.
- `id_dst`  in  REG_ADDR_W  destination register.
- `id_wr`  in  1  instruction writes `id_dst`.
- `id_load`  in  1  instruction is a load; its result is available only at the end of MEM.
- `reg1_sel`, `reg2_sel`, `ST_reg_sel`  out  2 each  registered selects for EX: 00 = decode value, 01 = `mem_result`, 10 = `wb_result`, 11 never driven.
- `stall`  out  1  combinational; freezes IF/ID and forces a bubble into EX.
- `stall_count`  out  CNT_W  load-use stall cycles. Present only with `HFU_PERF_CNT_EN`.

## Operation
- Tag registers:
  - `ex_tag` = {valid, wr, load, dst} for the instruction currently in EX.
  - `mem_tag` = {valid, wr, dst} for the instruction currently in MEM.
- Per-source match, evaluated in ID against the current tags:
  - hitE = use & ex_tag.valid & ex_tag.wr & (src == ex_tag.dst).
  - hitM = use & mem_tag.valid & mem_tag.wr & (src == mem_tag.dst).
- Next select per source:
  - hitE: 01 (the EX producer will be in MEM).
  - else hitM: 10 (the MEM producer will be in WB).
  - else 00.
  - The younger producer always wins.
- Load-use: `stall` = id_valid & ~flush & ex_tag.load & any hitE (src1, src2 or src_st).
- The register file is write-before-read, so a producer in WB while the consumer is in ID needs no forwarding.
- Advance on each edge with `hold`=0:
  - `mem_tag` <= `ex_tag` (load bit dropped).
  - If `stall` or `flush` or ~`id_valid`: `ex_tag`.valid <= 0 and all selects <= 00 (bubble).
  - Otherwise: `ex_tag` <= ID fields and selects <= next selects.
- A stalled instruction re-evaluates on the next cycle. The load is then in MEM, so the matching source gets 10 and `stall` falls.
- `hold`=1: tags, selects and counter all keep their values. `stall` is still driven combinationally from the held state.
- `flush` and `stall` in the same cycle: flush wins. Bubble inserted, no stall counted.
- Register 0 is an ordinary register and is forwarded like any other.

## Timing
- Reset values: selects 00, both tag valid bits 0, `stall` 0, `stall_count` 0.
- `rst` has priority over `hold`. A reset mid-stall drops the pending stall: the tags are invalid on the next cycle.
- Selects are valid for the whole EX cycle, one edge after the instruction's ID cycle (latency 1).
- Back-to-back dependent ALU ops: 0 stall cycles.
- Load then dependent instruction: exactly 1 stall cycle.

## Configuration
- `HFU_PERF_CNT_EN` defined:
  - `stall_count` exists.
  - It increments by 1 on each edge with `stall`=1 and `hold`=0, saturating at all-ones.
  - Reset clears it.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `cpu_pkg`:
  - `fwd_sel_t` enum: FWD_DEC=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - `stage_tag_t` struct.
  - `REG_ADDR_W` constant.
- One sub-module, `fwd_match`: takes one source address plus its use flag and both tags. It returns the next `fwd_sel_t` and hitE. It is instantiated three times.

## Test plan
- Reset, then idle with `id_valid`=0 -> all selects 00, `stall` 0, `stall_count` 0.
- ADD R3 followed by SUB using R3 as src1 -> `reg1_sel`=01 in the SUB's EX cycle, no stall.
- ADD R3, NOP, then a store with src_st=R3 -> `ST_reg_sel`=10.
- LOAD R5, then ADD with src2=R5 -> `stall`=1 for exactly one cycle, EX bubble with selects 00, then `reg2_sel`=10. `stall_count`=1 when `HFU_PERF_CNT_EN` is defined.
- R7 written by both the EX and MEM producers, consumer reads R7 -> 01 (younger wins).
- Load-use stall asserted with `hold`=1 for 3 cycles, then `flush`=1 -> tags frozen during hold; flush gives a bubble, `stall` deasserts and the counter does not change.
